single_to_unsigned_int: RTL and testbench

//   Converts an IEEE-754 single-precision float to a 32-bit unsigned integer.

---
 rtl/single_to_unsigned_int.sv | 103 ++++++++++
 tb/tb_single_to_unsigned_int.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/single_to_unsigned_int.sv
// single_to_unsigned_int
// Converts an IEEE-754 single-precision operand to a 32-bit unsigned integer,
// truncating toward zero and saturating out-of-range values. Fully pipelined:
// one operand per clock, result on z after the fourth register layer
// (a sampled at edge N is visible on z after edge N+3).
module single_to_unsigned_int (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  output logic [31:0] z
);

  // Stage 1 registers: captured operand and its unpacked fields
  logic [31:0] r_a;
  logic        r_sign;
  logic [7:0]  r_exp;
  logic [22:0] r_frac;
  logic [23:0] r_mant;
  logic        r_zeroDenorm;

  // Stage 2 register: classified and shifted result
  logic [31:0] r_result;

  // Combinational classification and barrel shift between stage 1 and 2
  logic [31:0] w_result;
  logic [31:0] w_mantWide;
  logic [4:0]  w_leftAmt;
  logic [4:0]  w_rightAmt;

  assign w_mantWide = {8'd0, r_mant};

  // Shift distances only matter inside 127..158, where they fit in 5 bits;
  // 150 mod 32 is 22, so the low exponent bits give the distance directly.
  assign w_leftAmt  = r_exp[4:0] - 5'd22;
  assign w_rightAmt = 5'd22 - r_exp[4:0];

  // Capture the raw operand so nothing downstream sees the input port directly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
    end else begin
      r_a <= a;
    end
  end

  // Unpack sign, exponent and fraction; restore the hidden bit for normals
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign       <= 1'b0;
      r_exp        <= '0;
      r_frac       <= '0;
      r_mant       <= '0;
      r_zeroDenorm <= 1'b0;
    end else begin
      r_sign       <= r_a[31];
      r_exp        <= r_a[30:23];
      r_frac       <= r_a[22:0];
      r_mant       <= {(r_a[30:23] != 8'd0), r_a[22:0]};
      r_zeroDenorm <= (r_a[30:23] == 8'd0);
    end
  end

  // Classify the operand and pick a saturated, zeroed or shifted result
  always_comb begin
    w_result = '0;
    if (r_exp == 8'hFF && r_frac != 23'd0) begin
      w_result = '0;
    end else if (r_sign) begin
      w_result = '0;
    end else if (r_exp == 8'hFF) begin
      w_result = 32'hFFFF_FFFF;
    end else if (r_zeroDenorm) begin
      w_result = '0;
    end else if (r_exp < 8'd127) begin
      w_result = '0;
    end else if (r_exp > 8'd158) begin
      w_result = 32'hFFFF_FFFF;
    end else if (r_exp >= 8'd150) begin
      w_result = w_mantWide << w_leftAmt;
    end else begin
      w_result = w_mantWide >> w_rightAmt;
    end
  end

  // Register the classified result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
    end else begin
      r_result <= w_result;
    end
  end

  // Drive the output purely from a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      z <= '0;
    end else begin
      z <= r_result;
    end
  end

endmodule

// File: tb/tb_single_to_unsigned_int.sv
// tb_single_to_unsigned_int
// Self-checking bench for the float-to-unsigned converter: directed vector
// table, reset behaviour, streaming, mid-stream reset and a random sweep
// against an independent reference model.
module tb_single_to_unsigned_int;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] z;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] a;
    logic [31:0] expected;
    string       name;
  } vector_t;

  vector_t     vectors[19];
  logic [31:0] expQ[$];

  single_to_unsigned_int dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .z   (z)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference conversion written in terms of value magnitude
  function automatic logic [31:0] refModel(input logic [31:0] v);
    logic [7:0]  ex;
    logic [22:0] fr;
    logic [63:0] mag;
    ex = v[30:23];
    fr = v[22:0];
    if (ex == 8'hFF && fr != 0) return 32'd0;
    if (v[31]) return 32'd0;
    if (ex == 8'hFF) return 32'hFFFF_FFFF;
    if (ex < 8'd127) return 32'd0;
    if (int'(ex) - 127 > 31) return 32'hFFFF_FFFF;
    mag = {40'd1, fr};
    mag = (mag << (int'(ex) - 127)) >> 23;
    return mag[31:0];
  endfunction

  // Drive a new operand half a cycle before the active edge
  task automatic applyStimulus(input logic [31:0] v);
    @(negedge clk);
    a = v;
  endtask

  // Compare z against a bench-computed value
  task automatic checkOutput(input string name, input logic [31:0] expected);
    checks++;
    if (z !== expected) begin
      failures++;
      $display("[TB] FAIL %s: z=%h expected=%h", name, z, expected);
    end
  endtask

  // One streaming cycle: check the result due now, then drive the next operand
  task automatic streamStep(input logic [31:0] v, input logic [31:0] e, input string name);
    @(negedge clk);
    if (expQ.size() == 4) begin
      checkOutput(name, expQ.pop_front());
    end else begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: queue depth=%0d expected=4", name, expQ.size());
    end
    a = v;
    expQ.push_back(e);
  endtask

  // Clear the pipeline and prime the scoreboard with the zeros it holds
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    a   = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    for (int i = 0; i < 4; i++) expQ.push_back(32'd0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    a        = 32'h3F80_0000;

    vectors[0]  = '{32'h3F80_0000, 32'h0000_0001, "one"};
    vectors[1]  = '{32'h4070_0000, 32'h0000_0003, "three_75"};
    vectors[2]  = '{32'h3F00_0000, 32'h0000_0000, "half"};
    vectors[3]  = '{32'h4F7F_FFFF, 32'hFFFF_FF00, "max_below_2p32"};
    vectors[4]  = '{32'h4F80_0000, 32'hFFFF_FFFF, "two_p32"};
    vectors[5]  = '{32'h7F80_0000, 32'hFFFF_FFFF, "pos_inf"};
    vectors[6]  = '{32'hBF80_0000, 32'h0000_0000, "neg_one"};
    vectors[7]  = '{32'h8000_0000, 32'h0000_0000, "neg_zero"};
    vectors[8]  = '{32'hFF80_0000, 32'h0000_0000, "neg_inf"};
    vectors[9]  = '{32'h7FC0_0000, 32'h0000_0000, "qnan"};
    vectors[10] = '{32'h0000_0001, 32'h0000_0000, "denormal"};
    vectors[11] = '{32'h4B00_0000, 32'h0080_0000, "two_p23"};
    vectors[12] = '{32'h4B7F_FFFF, 32'h00FF_FFFF, "ue23_max"};
    vectors[13] = '{32'h4AFF_FFFF, 32'h007F_FFFF, "ue22_max"};
    vectors[14] = '{32'h3FFF_FFFF, 32'h0000_0001, "just_below_two"};
    vectors[15] = '{32'h3F7F_FFFF, 32'h0000_0000, "just_below_one"};
    vectors[16] = '{32'h42F6_E979, 32'h0000_007B, "v123_456"};
    vectors[17] = '{32'h4F00_0000, 32'h8000_0000, "two_p31"};
    vectors[18] = '{32'h7F80_0001, 32'h0000_0000, "snan"};

    // Reset state and the idle cycles before the first operand emerges
    repeat (2) @(negedge clk);
    checkOutput("reset_z", 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_reset_idle", 32'd0);
    end
    @(negedge clk);
    checkOutput("first_after_reset", 32'd1);

    // Directed table: hold each operand long enough to fill the pipeline
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vectors[i].a);
      repeat (4) @(negedge clk);
      checkOutput(vectors[i].name, vectors[i].expected);
    end

    // Back-to-back stream 1.0 .. 10.0 with hand-derived results
    doReset();
    streamStep(32'h3F80_0000, 32'd1,  "stream");
    streamStep(32'h4000_0000, 32'd2,  "stream");
    streamStep(32'h4040_0000, 32'd3,  "stream");
    streamStep(32'h4080_0000, 32'd4,  "stream");
    streamStep(32'h40A0_0000, 32'd5,  "stream");
    streamStep(32'h40C0_0000, 32'd6,  "stream");
    streamStep(32'h40E0_0000, 32'd7,  "stream");
    streamStep(32'h4100_0000, 32'd8,  "stream");
    streamStep(32'h4110_0000, 32'd9,  "stream");
    streamStep(32'h4120_0000, 32'd10, "stream");
    for (int i = 0; i < 4; i++) streamStep(32'd0, 32'd0, "stream_drain");

    // Reset while 5.0, 6.0, 7.0 are in flight; 8.0 is presented during reset
    applyStimulus(32'h40A0_0000);
    applyStimulus(32'h40C0_0000);
    applyStimulus(32'h40E0_0000);
    @(negedge clk);
    rst = 1'b1;
    a   = 32'h4100_0000;
    @(negedge clk);
    checkOutput("midreset_z", 32'd0);
    rst = 1'b0;
    a   = 32'h4110_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("midreset_flush", 32'd0);
    end
    @(negedge clk);
    checkOutput("midreset_next", 32'd9);
    a = 32'd0;

    // Random sweep against the reference model
    doReset();
    for (int i = 0; i < 5000; i++) begin
      logic [31:0] rv;
      rv = $urandom;
      streamStep(rv, refModel(rv), "random");
    end
    for (int i = 0; i < 4; i++) streamStep(32'd0, 32'd0, "random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
